// File: rtl/keypad_pkg.sv
// Shared types and sizing helpers for the matrix keypad scanner.
package keypad_pkg;

    // Scan engine states; stepping to the next row is folded into the last DRIVE cycle.
    typedef enum logic {
        DRIVE  = 1'b0,
        UPDATE = 1'b1
    } scan_state_t;

    // A frame result, candidate or stable key is {none, code}; code is 0 whenever none is set,
    // so a whole-vector compare is enough to detect a change.
    localparam logic NO_KEY = 1'b1;

    function automatic int key_w(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

    function automatic int pad_w(input int num_pads);
        return (num_pads > 1) ? $clog2(num_pads) : 1;
    endfunction

    // Event packing, MSB first: {pad, code, press}.
    function automatic int evt_w(input int num_pads, input int rows, input int cols);
        return pad_w(num_pads) + key_w(rows, cols) + 1;
    endfunction

endpackage

// File: rtl/keypad_array_evt_fifo.sv
// Synchronous event FIFO; a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module evt_fifo #(
    parameter int DEPTH = 4,   // power of two, >= 2
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer update; extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/keypad_array.sv
// N-pad matrix keypad scanner: shared row scan, column sync, per-pad debounce, event FIFO.
module keypad_array
    import keypad_pkg::*;
#(
    parameter int NUM_PADS  = 2,
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int SCAN_DIV  = 25000,  // >= 4
    parameter int DEBOUNCE  = 4,      // >= 1
    parameter int EVT_DEPTH = 4,      // power of two
    localparam int KEY_W    = key_w(ROWS, COLS),
    localparam int PAD_W    = pad_w(NUM_PADS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PADS*COLS-1:0]  cols,
    output logic [NUM_PADS*ROWS-1:0]  rows,
    output logic [NUM_PADS*KEY_W-1:0] keycode,
    output logic [NUM_PADS-1:0]       pressed,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [PAD_W-1:0]          evt_pad,
    output logic [KEY_W-1:0]          evt_code,
    output logic                      evt_press,
    output logic                      evt_overflow
);
    localparam int EVT_W = evt_w(NUM_PADS, ROWS, COLS);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    scan_state_t state, state_nxt;
    logic [ROW_W-1:0] row, row_nxt;
    logic [DIV_W-1:0] div, div_nxt;
    logic [PAD_W-1:0] upd_pad, upd_pad_nxt;
    logic             latch, upd;

    logic [NUM_PADS*COLS-1:0]               cols_s1, cols_s2;
    logic [NUM_PADS-1:0][ROWS*COLS-1:0]     image;      // 1 = key seen down this frame
    logic [NUM_PADS-1:0]                    ev_push;
    logic [NUM_PADS-1:0][EVT_W-1:0]         ev_data;
    logic                                   push;
    logic [EVT_W-1:0]                       push_data;
    logic                                   fifo_full, fifo_empty, pop;

    // Scan state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DRIVE;
            row     <= '0;
            div     <= '0;
            upd_pad <= '0;
        end else begin
            state   <= state_nxt;
            row     <= row_nxt;
            div     <= div_nxt;
            upd_pad <= upd_pad_nxt;
        end
    end

    // Scan next-state: hold each row SCAN_DIV cycles, then one UPDATE cycle per pad.
    always_comb begin
        state_nxt   = state;
        row_nxt     = row;
        div_nxt     = div;
        upd_pad_nxt = upd_pad;
        latch       = 1'b0;
        upd         = 1'b0;
        case (state)
            DRIVE: begin
                if (div == DIV_W'(SCAN_DIV - 1)) begin
                    latch   = 1'b1;
                    div_nxt = '0;
                    if (row == ROW_W'(ROWS - 1)) begin
                        state_nxt   = UPDATE;
                        upd_pad_nxt = '0;
                    end else begin
                        row_nxt = row + 1'b1;
                    end
                end else begin
                    div_nxt = div + 1'b1;
                end
            end
            UPDATE: begin
                upd = 1'b1;
                if (upd_pad == PAD_W'(NUM_PADS - 1)) begin
                    state_nxt = DRIVE;
                    row_nxt   = '0;
                end else begin
                    upd_pad_nxt = upd_pad + 1'b1;
                end
            end
            default: state_nxt = DRIVE;
        endcase
    end

    // Row drive: current row low on every pad; all high in UPDATE and while in reset.
    always_comb begin
        rows = '1;
        if (!rst && state == DRIVE)
            for (int p = 0; p < NUM_PADS; p++) rows[p*ROWS + int'(row)] = 1'b0;
    end

    // Two-flop column synchroniser; idles high like the pulled-up inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cols_s1 <= '1;
            cols_s2 <= '1;
        end else begin
            cols_s1 <= cols;
            cols_s2 <= cols_s1;
        end
    end

    // Capture the driven row's columns into the frame image on the row's last cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            image <= '0;
        end else if (latch) begin
            for (int p = 0; p < NUM_PADS; p++)
                image[p][int'(row)*COLS +: COLS] <= ~cols_s2[p*COLS +: COLS];
        end
    end

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        logic [KEY_W:0]     res, cand, cand_nxt, stab;
        logic [CNT_W-1:0]   cnt, cnt_nxt;
        logic               accept;

        // Frame result: lowest pressed keycode wins.
        always_comb begin
            res = {NO_KEY, {KEY_W{1'b0}}};
            for (int k = ROWS*COLS - 1; k >= 0; k--)
                if (image[p][k]) res = {~NO_KEY, KEY_W'(k)};
        end

        // Debounce step for this pad's UPDATE cycle.
        always_comb begin
            cand_nxt = res;
            cnt_nxt  = CNT_W'(1);
            if (res == cand) begin
                cand_nxt = cand;
                cnt_nxt  = (cnt == CNT_W'(DEBOUNCE)) ? cnt : cnt + 1'b1;
            end
            accept = (cnt_nxt == CNT_W'(DEBOUNCE)) && (cand_nxt != stab);
        end

        // Debounce state; only this pad's UPDATE cycle advances it.
        always_ff @(posedge clk) begin
            if (rst) begin
                cand <= {NO_KEY, {KEY_W{1'b0}}};
                stab <= {NO_KEY, {KEY_W{1'b0}}};
                cnt  <= '0;
            end else if (upd && upd_pad == PAD_W'(p)) begin
                cand <= cand_nxt;
                cnt  <= cnt_nxt;
                if (accept) stab <= cand_nxt;
            end
        end

        // Release reports the key being let go; K->J reports only the press of J.
        assign ev_push[p] = upd && (upd_pad == PAD_W'(p)) && accept;
        assign ev_data[p] = {PAD_W'(p),
                             (cand_nxt[KEY_W] == NO_KEY) ? stab[KEY_W-1:0] : cand_nxt[KEY_W-1:0],
                             cand_nxt[KEY_W] != NO_KEY};
        assign keycode[p*KEY_W +: KEY_W] = stab[KEY_W-1:0];
        assign pressed[p]                = (stab[KEY_W] != NO_KEY);
    end

    // Only one pad is in UPDATE per cycle, so at most one push request is live.
    always_comb begin
        push      = 1'b0;
        push_data = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            if (ev_push[p]) begin
                push      = 1'b1;
                push_data = ev_data[p];
            end
        end
    end

    assign evt_valid = !fifo_empty;
    assign pop       = evt_valid && evt_ready;

    evt_fifo #(.DEPTH(EVT_DEPTH), .WIDTH(EVT_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_data),
        .pop   (pop),
        .dout  ({evt_pad, evt_code, evt_press}),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sticky drop flag: a push met a full FIFO with no pop to make room.
    always_ff @(posedge clk) begin
        if (rst)                                evt_overflow <= 1'b0;
        else if (push && fifo_full && !pop)     evt_overflow <= 1'b1;
    end

endmodule

// File: tb/tb_keypad_array.sv
// Bench for keypad_array: table of frames, hand sequences, random frames vs a frame-level model.
module tb_keypad_array;
    localparam int NP = 2, R = 4, C = 4, SD = 4, DEB = 2, DEPTH = 4;
    localparam int FRAME = R*SD + NP;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] cols, rows, keycode;
    logic [1:0] pressed;
    logic       evt_valid, evt_ready = 1'b0, evt_pad, evt_press, evt_overflow;
    logic [3:0] evt_code;

    keypad_array #(.NUM_PADS(NP), .ROWS(R), .COLS(C), .SCAN_DIV(SD),
                   .DEBOUNCE(DEB), .EVT_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cols(cols), .rows(rows), .keycode(keycode),
        .pressed(pressed), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_pad(evt_pad), .evt_code(evt_code), .evt_press(evt_press),
        .evt_overflow(evt_overflow));

    always #20 clk = ~clk;

    // Physical key matrix: a held key pulls its column low while its row is driven low.
    logic [15:0] keys [NP];
    always_comb begin
        cols = '1;
        for (int p = 0; p < NP; p++)
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    if (keys[p][r*C + c] && !rows[p*R + r]) cols[p*C + c] = 1'b0;
    end

    typedef struct { int pad; int code; bit press; } ev_t;
    typedef struct { logic [15:0] k0, k1; logic [1:0] p; logic [3:0] kc0, kc1; } vec_t;

    ev_t mq[$];
    int  cand [NP], cnt [NP], stab [NP];
    bit  movf, will_pop;
    int  checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int lowest(input logic [15:0] k);
        for (int i = 0; i < 16; i++) if (k[i]) return i;
        return -1;
    endfunction

    function automatic int kc(input int s);
        return (s < 0) ? 0 : s;
    endfunction

    task automatic model_reset();
        mq.delete();
        movf = 0;
        for (int p = 0; p < NP; p++) begin cand[p] = -1; cnt[p] = 0; stab[p] = -1; end
    endtask

    // Consumer side: every accepted head is compared against the oldest modelled event.
    initial forever begin
        @(negedge clk); #2;
        will_pop = (evt_valid === 1'b1) && evt_ready;
        if (will_pop) begin
            if (mq.size() == 0) chk("evt_unexpected", evt_valid, 0);
            else begin
                chk("evt_pad",   evt_pad,   mq[0].pad);
                chk("evt_code",  evt_code,  mq[0].code);
                chk("evt_press", evt_press, mq[0].press);
            end
        end
        @(posedge clk);
        if (will_pop && mq.size() > 0) void'(mq.pop_front());
    end

    task automatic do_reset();
        evt_ready = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rows", rows, 8'hFF);
        chk("rst_keycode", keycode, 0);
        chk("rst_pressed", pressed, 0);
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_overflow", evt_overflow, 0);
        model_reset();
        rst = 1'b0;
        #1 chk("first_rows", rows, 8'hEE);
    endtask

    // One full frame. rmode: 0 ready low, 1 ready high, 2 ready high only at pad 0's UPDATE edge.
    task automatic run_frame(input logic [15:0] k0, input logic [15:0] k1, input int rmode);
        ev_t ev [NP];
        bit  has [NP];
        int  old [NP];
        bit  drop;
        keys[0] = k0; keys[1] = k1;
        evt_ready = (rmode == 1);
        for (int p = 0; p < NP; p++) begin
            int res;
            res = lowest(keys[p]);
            old[p] = stab[p];
            has[p] = 0;
            if (res == cand[p]) begin if (cnt[p] < DEB) cnt[p]++; end
            else begin cand[p] = res; cnt[p] = 1; end
            if (cnt[p] == DEB && cand[p] != stab[p]) begin
                has[p] = 1;
                ev[p].pad = p; ev[p].press = (cand[p] >= 0);
                ev[p].code = (cand[p] >= 0) ? cand[p] : stab[p];
                stab[p] = cand[p];
            end
        end
        repeat (FRAME - NP) @(posedge clk);
        for (int p = 0; p < NP; p++) begin
            @(negedge clk);
            if (p == 1) begin
                chk("mid_kc0", keycode[3:0], kc(stab[0]));
                chk("mid_pr0", pressed[0], stab[0] >= 0);
                chk("mid_kc1", keycode[7:4], kc(old[1]));
                chk("mid_pr1", pressed[1], old[1] >= 0);
            end
            if (rmode == 2) evt_ready = (p == 0);
            #3;
            drop = has[p] && mq.size() >= DEPTH && !will_pop;
            @(posedge clk);
            if (drop) movf = 1;
            else if (has[p]) mq.push_back(ev[p]);
        end
        @(negedge clk);
        chk("kc0", keycode[3:0], kc(stab[0]));
        chk("kc1", keycode[7:4], kc(stab[1]));
        chk("pressed", pressed, {stab[1] >= 0, stab[0] >= 0});
        chk("overflow", evt_overflow, movf);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    vec_t tbl [15];
    logic [15:0] rk [NP];
    int hold [NP];

    initial begin
        tbl[0]  = '{16'h0040, 16'h0000, 2'b00, 4'd0,  4'd0};
        tbl[1]  = '{16'h0040, 16'h0000, 2'b01, 4'd6,  4'd0};
        tbl[2]  = '{16'h0040, 16'h0208, 2'b01, 4'd6,  4'd0};
        tbl[3]  = '{16'h0040, 16'h0208, 2'b11, 4'd6,  4'd3};
        tbl[4]  = '{16'h0040, 16'h0000, 2'b11, 4'd6,  4'd3};
        tbl[5]  = '{16'h0040, 16'h0000, 2'b01, 4'd6,  4'd0};
        tbl[6]  = '{16'h0000, 16'h0000, 2'b01, 4'd6,  4'd0};
        tbl[7]  = '{16'h0000, 16'h0000, 2'b00, 4'd0,  4'd0};
        tbl[8]  = '{16'h0020, 16'h0000, 2'b00, 4'd0,  4'd0};
        tbl[9]  = '{16'h0000, 16'h0000, 2'b00, 4'd0,  4'd0};
        tbl[10] = '{16'h0000, 16'h0000, 2'b00, 4'd0,  4'd0};
        tbl[11] = '{16'h8000, 16'h0001, 2'b00, 4'd0,  4'd0};
        tbl[12] = '{16'h8000, 16'h0001, 2'b11, 4'd15, 4'd0};
        tbl[13] = '{16'h0004, 16'h0001, 2'b11, 4'd15, 4'd0};
        tbl[14] = '{16'h0004, 16'h0001, 2'b11, 4'd2,  4'd0};
        keys[0] = '0; keys[1] = '0;
        model_reset();
        do_reset();

        for (int i = 0; i < 15; i++) begin
            run_frame(tbl[i].k0, tbl[i].k1, 1);
            chk($sformatf("tbl%0d_pressed", i), pressed, tbl[i].p);
            chk($sformatf("tbl%0d_kc0", i), keycode[3:0], tbl[i].kc0);
            chk($sformatf("tbl%0d_kc1", i), keycode[7:4], tbl[i].kc1);
        end

        // Both pads change together with the consumer stalled: pad 0 heads, and holds.
        run_frame(16'h0010, 16'h0100, 0);
        run_frame(16'h0010, 16'h0100, 0);
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", evt_valid, 1);
            chk("hold_pad", evt_pad, 0);
            chk("hold_code", evt_code, 4);
            chk("hold_press", evt_press, 1);
            @(negedge clk);
        end
        evt_ready = 1'b1;
        repeat (2) @(negedge clk);
        evt_ready = 1'b0;
        chk("drained_valid", evt_valid, 0);
        repeat (4) @(negedge clk);
        do_reset();   // lands inside row 2 of the frame

        // Five changes with no consumer: the fifth is dropped and the flag sticks.
        run_frame(16'h0002, 16'h0004, 0); run_frame(16'h0002, 16'h0004, 0);
        run_frame(16'h0000, 16'h0000, 0); run_frame(16'h0000, 16'h0000, 0);
        run_frame(16'h0080, 16'h0000, 0); run_frame(16'h0080, 16'h0000, 0);
        chk("ovf_set", evt_overflow, 1);
        chk("ovf_head_code", evt_code, 1);
        chk("ovf_head_press", evt_press, 1);
        run_frame(16'h0080, 16'h0000, 1);
        chk("ovf_drained", evt_valid, 0);
        chk("ovf_sticky", evt_overflow, 1);
        do_reset();

        // Same fill, but a pop coincides with the push into the full FIFO.
        run_frame(16'h0002, 16'h0004, 0); run_frame(16'h0002, 16'h0004, 0);
        run_frame(16'h0000, 16'h0000, 0); run_frame(16'h0000, 16'h0000, 0);
        run_frame(16'h0080, 16'h0000, 0); run_frame(16'h0080, 16'h0000, 2);
        chk("nodrop_ovf", evt_overflow, 0);
        chk("nodrop_valid", evt_valid, 1);
        run_frame(16'h0080, 16'h0000, 1);
        chk("nodrop_drained", evt_valid, 0);

        // Random key activity, random consumer stalls.
        rk[0] = '0; rk[1] = '0; hold[0] = 0; hold[1] = 0;
        for (int f = 0; f < 60; f++) begin
            for (int p = 0; p < NP; p++) begin
                if (hold[p] == 0) begin
                    case ($urandom % 4)
                        0: rk[p] = '0;
                        1: rk[p] = 16'h1 << ($urandom % 16);
                        2: rk[p] = (16'h1 << ($urandom % 16)) | (16'h1 << ($urandom % 16));
                        default: ;
                    endcase
                    hold[p] = $urandom_range(1, 3);
                end
                hold[p]--;
            end
            run_frame(rk[0], rk[1], $urandom % 3);
        end
        run_frame(rk[0], rk[1], 1);
        run_frame(rk[0], rk[1], 1);
        chk("final_drained", evt_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_array.md
# keypad_array

Parametrised N-pad matrix keypad scanner replacing the per-player keypad scanner instances in the Pong top level. One shared scan engine drives every pad's rows in lockstep, synchronises and debounces every pad's columns, and exposes per-pad stable keycodes. It also emits press/release events into a small FIFO with a valid/ready handshake for the game logic. Runs on the 25 MHz game clock.

## Interface
- NUM_PADS, 2, number of keypads (players)
- ROWS, 4, rows per pad
- COLS, 4, columns per pad
- SCAN_DIV, 25000, cycles each row is driven (1 ms at 25 MHz); must be ≥ 4
- DEBOUNCE, 4, consecutive identical frames required to accept a change; must be ≥ 1
- EVT_DEPTH, 4, event FIFO entries; power of two
- clk  in  1  game clock; one clock domain; reset is synchronous and active-high
- rst  in  1  synchronous active-high reset
- cols  in  NUM_PADS*COLS  column inputs, active-low (pulled up), pad p at [p*COLS +: COLS]
- rows  out  NUM_PADS*ROWS  row drives, active-low, pad p at [p*ROWS +: ROWS]
- keycode  out  NUM_PADS*KEY_W  stable keycode per pad; KEY_W = clog2(ROWS*COLS)
- pressed  out  NUM_PADS  stable "a key is held" per pad
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts head
- evt_pad  out  clog2(NUM_PADS) (min 1)  pad index of head event
- evt_code  out  KEY_W  keycode of head event
- evt_press  out  1  1 = press, 0 = release
- evt_overflow  out  1  sticky: an event was dropped

## Operation
- Keycode = row*COLS + col. With multiple keys down on a pad, the lowest keycode wins.
- Columns pass through a 2-flop synchroniser before use.
- FSM states:
  - DRIVE: row r is driven low on all pads for SCAN_DIV cycles. On the last cycle the synchronised cols are latched into the row image.
  - NEXT: if r < ROWS-1, r++ and go to DRIVE; otherwise go to UPDATE. NEXT takes zero extra cycles; it is folded into the last DRIVE cycle.
  - UPDATE: one cycle per pad, p = 0..NUM_PADS-1. All rows are high. Each cycle does debounce and event push for pad p. Then r = 0 and the FSM returns to DRIVE.
- Debounce per pad, on frame result R (key index, or none):
  - If R == candidate, count saturates upward.
  - Otherwise candidate = R and count = 1.
  - When count == DEBOUNCE and candidate != stable, stable = candidate and one event is pushed:
    - none→K: press K.
    - K→none: release K.
    - K→J: press J only; release of K is implied.
- FIFO behaviour:
  - Push when full is dropped and sets evt_overflow, unless a pop happens in the same cycle, in which case the push succeeds.
  - Pop when evt_valid && evt_ready.
  - Events leave in push order: ascending pad index within a frame.
- Reset: all internal state cleared and the FSM returns to DRIVE r=0. This applies mid-frame and mid-UPDATE; a partial frame is discarded. Output values during reset:
  - rows all 1
  - keycode 0, pressed 0
  - evt_valid 0, evt_overflow 0
  - FIFO empty, candidates none, counts 0

## Timing
- First cycle after rst deasserts: rows drives row 0 low.
- Frame length = ROWS*SCAN_DIV + NUM_PADS cycles.
- A col edge must be stable ≥ 3 cycles before the sample cycle to be captured in that frame (synchroniser).
- A change first captured in frame k becomes stable in the UPDATE of frame k+DEBOUNCE-1.
- keycode/pressed for pad p update the cycle after that pad's UPDATE cycle.
- evt_valid rises the cycle after the push; the FIFO has no bypass.
- evt_pad/code/press hold while evt_valid && !evt_ready.

## Structure
- keypad_pkg: KEY_W function, FSM state encoding (DRIVE, UPDATE), event field widths/packing {pad, code, press}, NO_KEY constant.
- Sub-module evt_fifo: parametrised synchronous FIFO (depth, width), with full/empty and the push-while-full-with-pop rule.
- Scan FSM, synchroniser and per-pad debounce live in keypad_array with a generate loop over pads.

## Test plan
All scenarios use NUM_PADS=2, ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE=2, EVT_DEPTH=4 unless stated.

- Reset mid-frame during row 2 → next cycle after release rows=8'hEE; keycode=0, pressed=0, evt_valid=0.
- Pad 0 holds row1/col2 from before frame 1 → end of frame 2 UPDATE: pressed[0]=1, keycode[0]=6; event {pad 0, code 6, press 1}; pad 1 unaffected.
- Pad 1 presses keys 3 and 9 simultaneously, then releases both → keycode[1]=3 with a press event; on release, event {pad 1, code 3, press 0}.
- A 1-frame glitch on pad 0 (key 5 for one frame only) → no stable change, no event.
- Both pads change in the same frame → two events, pad 0 first; evt_ready held low keeps the head stable across cycles.
- EVT_DEPTH=4 with evt_ready=0 and 5 distinct changes → 4 entries kept, evt_overflow=1 until rst. Repeat with evt_ready=1 on the full cycle → no drop.
